// File: rtl/bist_signature_checker.sv
// BIST signature checker: consumes PATTERN_COUNT valid compaction steps, captures the final
// CRC signature and compares it with the golden value. Optional watchdog: define BIST_TIMEOUT_EN.
module bist_signature_checker #(
    parameter int SIG_W       = 32,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             CK,
    input  logic             RESET,
    input  logic             START,
    input  logic             ABORT,
    input  logic [CNT_W-1:0] PATTERN_COUNT,
    input  logic [SIG_W-1:0] GOLDEN_SIG,
    input  logic [SIG_W-1:0] SIG_IN,
    input  logic             SIG_VALID,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic             FAIL,
    output logic             TIMEOUT,
    output logic [SIG_W-1:0] CAPTURED_SIG,
    output logic [CNT_W-1:0] REMAINING
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

    state_t           state, state_nxt;
    logic             pass_nxt, fail_nxt, timeout_nxt;
    logic [SIG_W-1:0] captured_nxt;
    logic [CNT_W-1:0] remaining_nxt;
    logic             last_valid;
    logic             wd_expire;

    assign last_valid = (state == S_RUN) && SIG_VALID && (REMAINING == CNT_W'(1));

`ifdef BIST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    // Expires on the idle RUN cycle that would bring the count up to TIMEOUT_CYC.
    assign wd_expire = (state == S_RUN) && !SIG_VALID && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CK or posedge RESET) begin
        if (RESET) begin
            wd_cnt <= '0;
        end else if (state != S_RUN || SIG_VALID) begin
            wd_cnt <= '0;
        end else if (!wd_expire) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge CK or posedge RESET) begin
        if (RESET) begin
            state        <= S_IDLE;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            PASS         <= 1'b0;
            FAIL         <= 1'b0;
            TIMEOUT      <= 1'b0;
            CAPTURED_SIG <= '0;
            REMAINING    <= '0;
        end else begin
            state        <= state_nxt;
            BUSY         <= (state_nxt == S_RUN) || (state_nxt == S_CHECK);
            DONE         <= (state_nxt == S_DONE);
            PASS         <= pass_nxt;
            FAIL         <= fail_nxt;
            TIMEOUT      <= timeout_nxt;
            CAPTURED_SIG <= captured_nxt;
            REMAINING    <= remaining_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (ABORT) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        state_nxt = (PATTERN_COUNT != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (last_valid) begin
                        state_nxt = S_CHECK;
                    end else if (wd_expire) begin
                        state_nxt = S_DONE;
                    end
                end
                S_CHECK: state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Result values are held by default so DONE keeps presenting them until START/ABORT.
    always_comb begin
        pass_nxt      = PASS;
        fail_nxt      = FAIL;
        timeout_nxt   = TIMEOUT;
        captured_nxt  = CAPTURED_SIG;
        remaining_nxt = REMAINING;
        if (ABORT) begin
            pass_nxt      = 1'b0;
            fail_nxt      = 1'b0;
            timeout_nxt   = 1'b0;
            remaining_nxt = '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        pass_nxt      = 1'b0;
                        fail_nxt      = (PATTERN_COUNT == '0);
                        timeout_nxt   = 1'b0;
                        remaining_nxt = PATTERN_COUNT;
                    end
                end
                S_RUN: begin
                    if (SIG_VALID && REMAINING != '0) begin
                        remaining_nxt = REMAINING - 1'b1;
                    end
                    if (last_valid) begin
                        captured_nxt = SIG_IN;
                    end
                    if (wd_expire) begin
                        pass_nxt    = 1'b0;
                        fail_nxt    = 1'b1;
                        timeout_nxt = 1'b1;
                    end
                end
                S_CHECK: begin
                    pass_nxt = (CAPTURED_SIG == GOLDEN_SIG);
                    fail_nxt = (CAPTURED_SIG != GOLDEN_SIG);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bist_signature_checker.sv
// Testbench for bist_signature_checker: directed scenarios plus randomized sessions checked
// against a session-level model (expected remaining count, captured signature, verdict).
module tb_bist_signature_checker;

   localparam int SIG_W = 32;
   localparam int CNT_W = 16;
   localparam int TCYC  = 8;

   logic             CK = 1'b0;
   logic             RESET, START, ABORT, SIG_VALID;
   logic [CNT_W-1:0] PATTERN_COUNT;
   logic [SIG_W-1:0] GOLDEN_SIG, SIG_IN;
   logic             BUSY, DONE, PASS, FAIL, TIMEOUT;
   logic [SIG_W-1:0] CAPTURED_SIG;
   logic [CNT_W-1:0] REMAINING;
   logic [4:0]       flags;

   int               nChecks = 0;
   int               nFail   = 0;
   logic [SIG_W-1:0] expCap  = '0;

   bist_signature_checker #(.SIG_W(SIG_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TCYC)) dut (
      .CK(CK), .RESET(RESET), .START(START), .ABORT(ABORT),
      .PATTERN_COUNT(PATTERN_COUNT), .GOLDEN_SIG(GOLDEN_SIG), .SIG_IN(SIG_IN),
      .SIG_VALID(SIG_VALID), .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .FAIL(FAIL),
      .TIMEOUT(TIMEOUT), .CAPTURED_SIG(CAPTURED_SIG), .REMAINING(REMAINING)
   );

   // Free-running clock with a 10-unit period.
   always #5 CK = ~CK;

   // {BUSY, DONE, PASS, FAIL, TIMEOUT}
   assign flags = {BUSY, DONE, PASS, FAIL, TIMEOUT};

   task automatic step();
      @(negedge CK);
   endtask

   // Counts every comparison and every mismatch, and reports the mismatches.
   task automatic checkOutput(input bit ok, input string msg);
      nChecks++;
      if (!ok) begin
         nFail++;
         $display("[TB] FAIL %s", msg);
      end
   endtask

   task automatic test_reset();
      RESET = 1'b1; START = 1'b0; ABORT = 1'b0; SIG_VALID = 1'b0;
      PATTERN_COUNT = '0; GOLDEN_SIG = '0; SIG_IN = '0;
      #3;
      checkOutput(flags === 5'b0 && CAPTURED_SIG === '0 && REMAINING === '0,
                  $sformatf("reset_initial: flags=%b cap=%h rem=%0d, want 0/0/0", flags, CAPTURED_SIG, REMAINING));
      step(); RESET = 1'b0; step();
      checkOutput(flags === 5'b0, $sformatf("reset_release: flags=%b want 00000", flags));

      PATTERN_COUNT = 16'd5; START = 1'b1; step(); START = 1'b0;
      SIG_VALID = 1'b1; SIG_IN = $urandom; step(); SIG_VALID = 1'b0;
      checkOutput(flags === 5'b10000 && REMAINING === 16'd4,
                  $sformatf("reset_prerun: flags=%b rem=%0d want 10000/4", flags, REMAINING));
      #2 RESET = 1'b1;
      #1;
      checkOutput(flags === 5'b0 && REMAINING === '0 && CAPTURED_SIG === '0,
                  $sformatf("reset_async: flags=%b rem=%0d cap=%h want all 0", flags, REMAINING, CAPTURED_SIG));
      step(); RESET = 1'b0; step(); step();
      checkOutput(flags === 5'b0 && REMAINING === '0,
                  $sformatf("reset_idle: flags=%b rem=%0d want 00000/0", flags, REMAINING));
      expCap = '0;
   endtask

   // Drives one complete session and checks it against the expected count-down and verdict.
   task automatic run_session(input logic [CNT_W-1:0] pc, input logic [SIG_W-1:0] finalSig,
                              input logic [SIG_W-1:0] golden, input int minGap,
                              input int maxGap, input bit noise, input string name);
      int rem;
      bit expPass;
      logic [4:0] expFlags;
      rem = int'(pc);
      expPass = (finalSig == golden);
      expFlags = {2'b01, expPass, !expPass, 1'b0};
      GOLDEN_SIG = golden; PATTERN_COUNT = pc; START = 1'b1; ABORT = 1'b0; SIG_VALID = 1'b0;
      step(); START = 1'b0;
      checkOutput(flags === 5'b10000 && REMAINING === pc,
                  $sformatf("%s_start: flags=%b rem=%0d want 10000/%0d", name, flags, REMAINING, pc));
      while (rem > 0) begin
         repeat ($urandom_range(minGap, maxGap)) begin
            SIG_VALID = 1'b0; SIG_IN = $urandom;
            if (noise) begin START = 1'($urandom); PATTERN_COUNT = CNT_W'($urandom); end
            step();
            checkOutput(BUSY === 1'b1 && DONE === 1'b0 && REMAINING === CNT_W'(rem),
                        $sformatf("%s_gap: busy=%b done=%b rem=%0d want 1/0/%0d", name, BUSY, DONE, REMAINING, rem));
         end
         SIG_VALID = 1'b1;
         SIG_IN = (rem == 1) ? finalSig : SIG_W'($urandom);
         if (noise) begin START = 1'($urandom); PATTERN_COUNT = CNT_W'($urandom); end
         step();
         rem--;
         checkOutput(BUSY === 1'b1 && DONE === 1'b0 && REMAINING === CNT_W'(rem),
                     $sformatf("%s_valid: busy=%b done=%b rem=%0d want 1/0/%0d", name, BUSY, DONE, REMAINING, rem));
      end
      checkOutput(CAPTURED_SIG === finalSig,
                  $sformatf("%s_capture: cap=%h want %h", name, CAPTURED_SIG, finalSig));
      SIG_VALID = 1'b0; START = 1'b0;
      step();
      checkOutput(flags === expFlags,
                  $sformatf("%s_verdict: flags=%b want %b", name, flags, expFlags));
      SIG_VALID = 1'b1; SIG_IN = $urandom;
      step(); SIG_VALID = 1'b0;
      checkOutput(flags === expFlags && CAPTURED_SIG === finalSig,
                  $sformatf("%s_hold: flags=%b cap=%h want %b/%h", name, flags, CAPTURED_SIG, expFlags, finalSig));
      expCap = finalSig;
   endtask

   task automatic test_pass();
      run_session(16'd4, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 0, 0, 1'b0, "pass");
   endtask

   task automatic test_fail_gaps();
      run_session(16'd3, 32'h0000_0001, 32'h0, 1, 3, 1'b0, "fail_gaps");
   endtask

   task automatic test_zero_count();
      ABORT = 1'b1; step(); ABORT = 1'b0;
      checkOutput(flags === 5'b0 && CAPTURED_SIG === expCap,
                  $sformatf("zero_abort: flags=%b cap=%h want 00000/%h", flags, CAPTURED_SIG, expCap));
      PATTERN_COUNT = '0; START = 1'b1; step(); START = 1'b0;
      checkOutput(flags === 5'b01010 && CAPTURED_SIG === expCap && REMAINING === '0,
                  $sformatf("zero_count: flags=%b cap=%h rem=%0d want 01010/%h/0", flags, CAPTURED_SIG, REMAINING, expCap));
      step();
      checkOutput(flags === 5'b01010, $sformatf("zero_hold: flags=%b want 01010", flags));
   endtask

   task automatic test_abort_start();
      PATTERN_COUNT = 16'd5; START = 1'b1; step(); START = 1'b0;
      checkOutput(flags === 5'b10000 && REMAINING === 16'd5,
                  $sformatf("abort_run: flags=%b rem=%0d want 10000/5", flags, REMAINING));
      ABORT = 1'b1; START = 1'b1; PATTERN_COUNT = 16'd7; step();
      ABORT = 1'b0; START = 1'b0;
      checkOutput(flags === 5'b0 && REMAINING === '0 && CAPTURED_SIG === expCap,
                  $sformatf("abort_start: flags=%b rem=%0d cap=%h want 00000/0/%h", flags, REMAINING, CAPTURED_SIG, expCap));
      step();
      checkOutput(flags === 5'b0 && REMAINING === '0,
                  $sformatf("abort_idle: flags=%b rem=%0d want 00000/0", flags, REMAINING));
      run_session(16'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1, 1'b0, "abort_pre");
      ABORT = 1'b1; step(); ABORT = 1'b0;
      checkOutput(flags === 5'b0 && CAPTURED_SIG === expCap,
                  $sformatf("abort_done: flags=%b cap=%h want 00000/%h", flags, CAPTURED_SIG, expCap));
   endtask

   task automatic test_back_to_back();
      run_session(16'd1, 32'h1234_5678, 32'h1234_5678, 0, 0, 1'b0, "b2b_a");
      run_session(16'd2, 32'h8765_4321, 32'h0, 0, 0, 1'b0, "b2b_b");
      run_session(16'd1, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 0, 1'b0, "b2b_c");
   endtask

   task automatic test_random();
      for (int s = 0; s < 20; s++) begin
         logic [SIG_W-1:0] fs, gs;
         fs = $urandom;
         gs = ($urandom_range(0, 1) == 1) ? fs : (fs ^ (SIG_W'(1) << $urandom_range(0, SIG_W - 1)));
         run_session(CNT_W'($urandom_range(1, 8)), fs, gs, 0, 2, 1'b1, "random");
      end
   endtask

   task automatic test_timeout();
      int cycles;
      ABORT = 1'b1; step(); ABORT = 1'b0;
      PATTERN_COUNT = 16'd3; START = 1'b1; step(); START = 1'b0;
      SIG_VALID = 1'b0;
`ifdef BIST_TIMEOUT_EN
      cycles = 0;
      while (DONE !== 1'b1 && cycles < 50) begin
         step();
         cycles++;
      end
      checkOutput(cycles == TCYC,
                  $sformatf("timeout_latency: cycles=%0d want %0d", cycles, TCYC));
      checkOutput(flags === 5'b01011 && CAPTURED_SIG === expCap,
                  $sformatf("timeout_flags: flags=%b cap=%h want 01011/%h", flags, CAPTURED_SIG, expCap));
`else
      cycles = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (flags !== 5'b10000) cycles++;
      end
      checkOutput(cycles == 0 && flags === 5'b10000 && REMAINING === 16'd3,
                  $sformatf("timeout_disabled: bad_cycles=%0d flags=%b rem=%0d want 0/10000/3", cycles, flags, REMAINING));
`endif
      ABORT = 1'b1; step(); ABORT = 1'b0;
   endtask

   // Runs every scenario in order, then reports the comparison totals.
   initial begin
      test_reset();
      test_pass();
      test_fail_gaps();
      test_zero_count();
      test_abort_start();
      test_back_to_back();
      test_random();
      test_timeout();
      $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
